// File: rtl/svlib_stream_pkg.sv
// svlib_stream_pkg: shared stream-buffer state encoding and occupancy helpers
package svlib_stream_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Entry count held in each state: EMPTY=0, BUSY=1, FULL=2
    function automatic logic [OCC_W-1:0] occ_of(state_t s);
        return (s == EMPTY) ? 2'd0 : (s == BUSY) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/register_en_async_rst.sv
// register_en_async_rst: load-enabled data register with asynchronous active-high reset
module register_en_async_rst #(
    parameter int                WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d only when enabled; reset clears immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= RESET_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/skid_buffer_async_rst.sv
// skid_buffer_async_rst: two-entry valid/ready register slice with fully registered handshake outputs
module skid_buffer_async_rst
    import svlib_stream_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [OCC_W-1:0] occupancy
);

    state_t           state;
    state_t           next_state;
    logic             in_hs;
    logic             out_hs;
    logic             main_en;
    logic             skid_en;
    logic [WIDTH-1:0] main_din;
    logic [WIDTH-1:0] skid_q;

    assign in_hs     = s_valid & s_ready;
    assign out_hs    = m_valid & m_ready;
    assign main_din  = (state == FULL) ? skid_q : s_data;
    assign occupancy = occ_of(state);

    // Next-state and register load enables from the handshake; flush overrides everything
    always_comb begin
        next_state = state;
        main_en    = 1'b0;
        skid_en    = 1'b0;
        case (state)
            EMPTY: begin
                main_en    = in_hs;
                next_state = in_hs ? BUSY : EMPTY;
            end
            BUSY: begin
                main_en    = in_hs & out_hs;
                skid_en    = in_hs & ~out_hs;
                next_state = (in_hs & ~out_hs) ? FULL : (~in_hs & out_hs) ? EMPTY : BUSY;
            end
            FULL: begin
                main_en    = out_hs;
                next_state = out_hs ? BUSY : FULL;
            end
            default: next_state = EMPTY;
        endcase
        if (flush) begin
            next_state = EMPTY;
            main_en    = 1'b0;
            skid_en    = 1'b0;
        end
    end

    // State plus registered handshake outputs; s_ready stays low until the first edge after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            state   <= next_state;
            s_ready <= (next_state != FULL);
            m_valid <= (next_state != EMPTY);
        end
    end

    register_en_async_rst #(
        .WIDTH     (WIDTH),
        .RESET_VAL ('0)
    ) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_din),
        .q   (m_data)
    );

    register_en_async_rst #(
        .WIDTH     (WIDTH),
        .RESET_VAL ('0)
    ) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (s_data),
        .q   (skid_q)
    );

    a_hold_data: assert property (@(posedge clk) disable iff (rst)
        (s_valid && !s_ready) |=> $stable(s_data))
        else $warning("s_data changed while stalled");

    a_occ_max: assert property (@(posedge clk) disable iff (rst)
        occupancy <= 2'd2)
        else $error("occupancy above 2");

endmodule
